hack_memory_map: RTL and testbench

Parametrised data-memory map for the Hack CPU, successor to the fixed 16-bit RAM-only memory block. It decodes one CPU address space into data RAM, a dual-ported screen buffer and a keyboard register. It adds a streaming scan-out port for the display controller, a registered keyboard input, and a sticky illegal-access flag. It sits between the CPU data port and the display/keyboard I/O controllers.

---
 rtl/hack_memory_map.sv | 94 +++++++++
 tb/tb_hack_memory_map.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hack_memory_map.sv
// hack_memory_map: Hack CPU data-memory map with RAM, dual-port screen buffer, keyboard register and scan-out stream.
module hack_memory_map #(
    parameter int WIDTH        = 16,
    parameter int ADDR_WIDTH   = 15,
    parameter int RAM_DEPTH    = 16384,
    parameter int SCREEN_BASE  = 16384,
    parameter int SCREEN_DEPTH = 8192,
    parameter int KBD_ADDR     = 24576
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic signed [WIDTH-1:0] in,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic                    load,
    output logic signed [WIDTH-1:0] out,
    input  logic                    kbd_valid,
    input  logic [WIDTH-1:0]        kbd_code,
    input  logic                    scan_en,
    input  logic                    scan_ready,
    output logic                    scan_valid,
    output logic [WIDTH-1:0]        scan_data,
    output logic                    scan_last,
    output logic                    bad_access
);
    localparam int RAM_AW = RAM_DEPTH > 1 ? $clog2(RAM_DEPTH) : 1;
    localparam int SCR_AW = SCREEN_DEPTH > 1 ? $clog2(SCREEN_DEPTH) : 1;
    localparam logic [SCR_AW-1:0] SCR_LAST = SCR_AW'(SCREEN_DEPTH - 1);

    if (SCREEN_BASE < RAM_DEPTH || KBD_ADDR < RAM_DEPTH ||
        (KBD_ADDR >= SCREEN_BASE && KBD_ADDR < SCREEN_BASE + SCREEN_DEPTH)) begin : g_overlap
        $error("hack_memory_map: address regions overlap");
    end

    logic [WIDTH-1:0]  ram_mem [RAM_DEPTH];
    logic [WIDTH-1:0]  scr_mem [SCREEN_DEPTH];
    logic [31:0]       addr_w;
    logic              ram_hit, scr_hit, kbd_hit, advance;
    logic [RAM_AW-1:0] ram_idx;
    logic [SCR_AW-1:0] scr_idx;
    logic [WIDTH-1:0]  kbd_q, kbd_d, data_q, data_d;
    logic [SCR_AW-1:0] ptr_q, ptr_d;
    logic              valid_q, valid_d, last_q, last_d, bad_q, bad_d;

    assign addr_w  = 32'(address);
    assign ram_hit = addr_w < 32'(RAM_DEPTH);
    assign scr_hit = addr_w >= 32'(SCREEN_BASE) && addr_w < 32'(SCREEN_BASE + SCREEN_DEPTH);
    assign kbd_hit = addr_w == 32'(KBD_ADDR);
    assign ram_idx = RAM_AW'(address);
    assign scr_idx = SCR_AW'(addr_w - 32'(SCREEN_BASE));
    assign advance = scan_en && (!valid_q || scan_ready);

    always_ff @(posedge CLK) begin
        if (load && ram_hit) ram_mem[ram_idx] <= in;
    end

    // Scan fetch reads scr_mem in a separate process, so a same-edge CPU write is seen only afterwards.
    always_ff @(posedge CLK) begin
        if (load && scr_hit) scr_mem[scr_idx] <= in;
    end

    assign out = ram_hit ? ram_mem[ram_idx] : scr_hit ? scr_mem[scr_idx] : kbd_hit ? kbd_q : '0;

    always_comb begin
        kbd_d   = kbd_valid ? kbd_code : kbd_q;
        bad_d   = bad_q || (load && !ram_hit && !scr_hit);
        ptr_d   = advance ? (ptr_q == SCR_LAST ? '0 : ptr_q + SCR_AW'(1)) : ptr_q;
        valid_d = advance || (valid_q && !scan_ready);
        data_d  = advance ? scr_mem[ptr_q] : data_q;
        last_d  = advance ? ptr_q == SCR_LAST : last_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            kbd_q   <= '0;
            bad_q   <= 1'b0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            kbd_q   <= kbd_d;
            bad_q   <= bad_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign scan_valid = valid_q;
    assign scan_data  = data_q;
    assign scan_last  = last_q;
    assign bad_access = bad_q;
endmodule

// File: tb/tb_hack_memory_map.sv
// tb_hack_memory_map: randomized and directed checks of hack_memory_map against an array-based memory model.
module tb_hack_memory_map;
    localparam int W = 16;
    localparam int AW = 15;
    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [W-1:0]  in = '0;
    logic [AW-1:0] address = '0;
    logic          load = 1'b0;
    logic [W-1:0]  out;
    logic          kbd_valid = 1'b0;
    logic [W-1:0]  kbd_code = '0;
    logic          scan_en = 1'b0;
    logic          scan_ready = 1'b0;
    logic          scan_valid, scan_last, bad_access;
    logic [W-1:0]  scan_data;
    int            checks = 0;
    int            failures = 0;
    logic [W-1:0]  ram_m [16384];
    logic [W-1:0]  scr_m [8192];
    logic [W-1:0]  kbd_m = '0;
    logic          bad_m = 1'b0;
    logic [AW-1:0] pool [16];

    hack_memory_map dut (
        .CLK(CLK), .RST_N(RST_N), .in(in), .address(address), .load(load), .out(out),
        .kbd_valid(kbd_valid), .kbd_code(kbd_code), .scan_en(scan_en), .scan_ready(scan_ready),
        .scan_valid(scan_valid), .scan_data(scan_data), .scan_last(scan_last), .bad_access(bad_access)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_read(input int a);
        if (a < 16384) return ram_m[a];
        if (a < 24576) return scr_m[a - 16384];
        if (a == 24576) return kbd_m;
        return '0;
    endfunction

    // One CPU cycle: check out before the edge, update the model at the edge, check bad_access after.
    task automatic cycle(input logic ld, input int a, input logic [W-1:0] d, input logic kv, input logic [W-1:0] kc, input string tag);
        logic [W-1:0] exp;
        load = ld; address = AW'(a); in = d; kbd_valid = kv; kbd_code = kc;
        #1;
        exp = model_read(a);
        if (!$isunknown(exp)) check({tag, "_rd"}, out, exp);
        check({tag, "_bad_pre"}, bad_access, bad_m);
        @(posedge CLK);
        if (ld && a < 16384) ram_m[a] = d;
        else if (ld && a < 24576) scr_m[a - 16384] = d;
        else if (ld) bad_m = 1'b1;
        if (kv) kbd_m = kc;
        #1;
        check({tag, "_bad"}, bad_access, bad_m);
    endtask

    task automatic do_reset();
        RST_N = 1'b0; load = 1'b0; kbd_valid = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1; kbd_m = '0; bad_m = 1'b0;
    endtask

    initial begin
        int exp_idx;
        logic stall;
        do_reset();
        address = AW'(24576);
        #1;
        check("rst_valid", scan_valid, 1'b0);
        check("rst_bad", bad_access, 1'b0);
        check("rst_data", scan_data, 16'h0);
        check("rst_last", scan_last, 1'b0);
        check("rst_kbd_out", out, 16'h0);
        cycle(1'b1, 100, 16'h7FFF, 1'b0, '0, "wr100");
        cycle(1'b1, 16384, 16'h8000, 1'b0, '0, "wr16384");
        cycle(1'b0, 100, '0, 1'b0, '0, "rd100");
        check("rd100_const", out, 16'h7FFF);
        cycle(1'b0, 16384, '0, 1'b0, '0, "rd16384");
        check("rd16384_const", out, 16'h8000);
        cycle(1'b0, 24577, '0, 1'b0, '0, "rd24577");
        cycle(1'b1, 100, 16'h1234, 1'b0, '0, "wr_rd_same");
        cycle(1'b0, 100, '0, 1'b0, '0, "rd_new");
        cycle(1'b0, 24576, '0, 1'b1, 16'd65, "kbd_load");
        cycle(1'b0, 24576, '0, 1'b0, '0, "kbd_hold1");
        check("kbd_65", out, 16'd65);
        cycle(1'b0, 24576, '0, 1'b0, '0, "kbd_hold2");
        cycle(1'b1, 24576, 16'd5, 1'b0, '0, "kbd_wr");
        check("kbd_wr_bad", bad_access, 1'b1);
        cycle(1'b0, 24576, '0, 1'b0, '0, "kbd_after_wr");
        check("kbd_still_65", out, 16'd65);
        do_reset();
        address = AW'(24576);
        #1;
        check("rst2_bad", bad_access, 1'b0);
        check("rst2_kbd", out, 16'h0);
        pool[0] = AW'(0); pool[1] = AW'(16383); pool[2] = AW'(16384); pool[3] = AW'(24575);
        for (int i = 4; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0: pool[i] = AW'($urandom_range(0, 16383));
                1: pool[i] = AW'($urandom_range(16384, 24575));
                2: pool[i] = AW'(24576);
                default: pool[i] = AW'($urandom_range(24577, 32767));
            endcase
        end
        for (int i = 0; i < 16; i++)
            if (int'(pool[i]) < 24576) cycle(1'b1, int'(pool[i]), W'($urandom), 1'b0, '0, "pool_init");
        for (int i = 0; i < 400; i++) begin
            int a;
            a = int'(pool[$urandom_range(0, 15)]);
            cycle(a < 24576 && $urandom_range(0, 1) == 1, a, W'($urandom), $urandom_range(0, 3) == 0, W'($urandom), "rand");
        end
        cycle(1'b1, 30000, 16'hBEEF, 1'b0, '0, "unmapped_wr");
        check("unmapped_bad", bad_access, 1'b1);
        for (int i = 0; i < 8192; i++) cycle(1'b1, 16384 + i, W'(i), 1'b0, '0, "preload");
        load = 1'b0; address = '0; scan_en = 1'b1; scan_ready = 1'b1;
        @(posedge CLK);
        #1;
        check("scan_first_valid", scan_valid, 1'b1);
        check("scan_first_data", scan_data, 16'h0);
        exp_idx = 0;
        for (int c = 0; c < 8200; c++) begin
            stall = c >= 100 && c < 103;
            scan_ready = !stall;
            check("scan_valid", scan_valid, 1'b1);
            check(stall ? "scan_hold" : "scan_data", scan_data, scr_m[exp_idx]);
            check("scan_last", scan_last, exp_idx == 8191);
            if (!stall) exp_idx = (exp_idx + 1) % 8192;
            @(posedge CLK);
            #1;
        end
        scan_en = 1'b0; scan_ready = 1'b1;
        @(posedge CLK);
        #1;
        check("scan_drain", scan_valid, 1'b0);
        scan_en = 1'b0;
        do_reset();
        scan_en = 1'b1; scan_ready = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            load = n == 6; address = AW'(16389); in = 16'hAAAA;
            @(posedge CLK);
            #1;
            if (n == 6) scr_m[5] = 16'hAAAA;
            check("coll_valid", scan_valid, 1'b1);
            check("coll_data", scan_data, 32'(n - 1));
        end
        load = 1'b0;
        #1;
        check("coll_cpu_new", out, 16'hAAAA);
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        check("midrst_valid", scan_valid, 1'b0);
        check("midrst_data", scan_data, 16'h0);
        check("midrst_last", scan_last, 1'b0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("restart_valid", scan_valid, 1'b1);
        check("restart_w0", scan_data, 16'h0);
        @(posedge CLK);
        #1;
        check("restart_w1", scan_data, 16'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
